// File: rtl/mem_bus_master.sv
// mem_bus_master
//   CPU-side initiator for the simulated memory bus. Takes one load/store
//   request at a time, runs a single CS/BE/RW/Addr bus cycle against the
//   memory responder, waits for the asynchronous DataReady handshake and
//   returns aligned, extended read data with a one-cycle Done pulse.
//   Misaligned requests and bus timeouts are reported with AddrErr/BusErr.
//
// Parameters
//   SYNC_STAGES     flip-flop stages synchronising DataReady (>= 2)
//   TIMEOUT_CYCLES  cycles allowed in STROBE or RELEASE before BusErr (1..255)
//
// Ports
//   Clk, Reset      system clock, asynchronous active-high reset
//   Req, Wr, Size,  CPU request: store/load, 00 byte / 01 half / 1x word,
//   SignExt, VAddr, load extension, byte address, right-justified store data
//   WData
//   Busy, Done,     request in progress, completion pulse,
//   RData,          load result (held until the next Done),
//   AddrErr, BusErr misalignment / timeout flags (pulse with Done)
//   CS, RW, BE,     bus chip select, direction, byte enables,
//   Addr, DataOut   word address VAddr[31:2], right-justified write data
//   DataIn,         read data from memory
//   DataReady       memory ready, asynchronous to Clk

module mem_bus_master #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] VAddr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RData,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        CS,
    output logic        RW,
    output logic [3:0]  BE,
    output logic [29:0] Addr,
    output logic [31:0] DataOut,
    input  logic [31:0] DataIn,
    input  logic        DataReady
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } stateT;

    // Counter value at which the final allowed wait cycle ends.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    stateT                  state;
    stateT                  nextState;
    logic [SYNC_STAGES-1:0] syncChain;
    logic                   rdySync;
    logic [7:0]             toCount;
    logic [7:0]             toCountNext;
    logic [1:0]             latSize;
    logic [1:0]             latSizeNext;
    logic                   latSignExt;
    logic                   latSignExtNext;

    logic                   csNext;
    logic                   rwNext;
    logic [3:0]             beNext;
    logic [29:0]            addrNext;
    logic [31:0]            dataOutNext;
    logic [31:0]            rDataNext;
    logic                   busyNext;
    logic                   doneNext;
    logic                   addrErrNext;
    logic                   busErrNext;

    // Half accesses need an even address, word (and reserved 11) accesses a
    // multiple of four; bytes are always aligned.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = offset[0];
            default: bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

    // Byte enables double as the size code on the bus.
    function automatic logic [3:0] byteEnables(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001;
            2'b01:   be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data stays right-justified; unused upper bytes are zeroed.
    function automatic logic [31:0] formatStore(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] data;
        case (size)
            2'b00:   data = {24'h00_0000, wdata[7:0]};
            2'b01:   data = {16'h0000, wdata[15:0]};
            default: data = wdata;
        endcase
        return data;
    endfunction

    // Read data arrives right-justified; extend byte/half to 32 bits.
    function automatic logic [31:0] extendLoad(input logic [1:0] size, input logic sx,
                                               input logic [31:0] din);
        logic [31:0] result;
        case (size)
            2'b00:   result = {{24{sx & din[7]}}, din[7:0]};
            2'b01:   result = {{16{sx & din[15]}}, din[15:0]};
            default: result = din;
        endcase
        return result;
    endfunction

    assign rdySync = syncChain[SYNC_STAGES-1];

    // DataReady synchroniser chain into the Clk domain.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], DataReady};
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state, next-output and timeout-counter logic.
    always_comb begin
        nextState      = state;
        toCountNext    = toCount;
        latSizeNext    = latSize;
        latSignExtNext = latSignExt;
        csNext         = CS;
        rwNext         = RW;
        beNext         = BE;
        addrNext       = Addr;
        dataOutNext    = DataOut;
        rDataNext      = RData;
        busyNext       = Busy;
        doneNext       = 1'b0;
        addrErrNext    = 1'b0;
        busErrNext     = 1'b0;

        case (state)
            IDLE: begin
                if (Req) begin
                    if (isMisaligned(Size, VAddr[1:0])) begin
                        // Rejected without touching the bus or RData.
                        doneNext    = 1'b1;
                        addrErrNext = 1'b1;
                    end else begin
                        latSizeNext    = Size;
                        latSignExtNext = SignExt;
                        rwNext         = Wr;
                        beNext         = byteEnables(Size);
                        addrNext       = VAddr[31:2];
                        dataOutNext    = formatStore(Size, WData);
                        busyNext       = 1'b1;
                        nextState      = SETUP;
                    end
                end else begin
                    nextState = IDLE;
                end
            end

            SETUP: begin
                // Bus fields have had a full cycle to settle before CS rises.
                csNext      = 1'b1;
                toCountNext = 8'd0;
                nextState   = STROBE;
            end

            STROBE: begin
                if (rdySync) begin
                    nextState = CAPTURE;
                end else if (toCount == TIMEOUT_LAST) begin
                    csNext     = 1'b0;
                    doneNext   = 1'b1;
                    busErrNext = 1'b1;
                    busyNext   = 1'b0;
                    nextState  = IDLE;
                end else begin
                    toCountNext = toCount + 8'd1;
                end
            end

            CAPTURE: begin
                if (RW == 1'b0) begin
                    rDataNext = extendLoad(latSize, latSignExt, DataIn);
                end else begin
                    rDataNext = RData;
                end
                csNext      = 1'b0;
                toCountNext = 8'd0;
                nextState   = RELEASE;
            end

            RELEASE: begin
                if (!rdySync) begin
                    doneNext  = 1'b1;
                    busyNext  = 1'b0;
                    nextState = IDLE;
                end else if (toCount == TIMEOUT_LAST) begin
                    doneNext   = 1'b1;
                    busErrNext = 1'b1;
                    busyNext   = 1'b0;
                    nextState  = IDLE;
                end else begin
                    toCountNext = toCount + 8'd1;
                end
            end

            default: begin
                csNext    = 1'b0;
                busyNext  = 1'b0;
                nextState = IDLE;
            end
        endcase
    end

    // Registered bus, CPU-side outputs and latched request attributes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            CS         <= 1'b0;
            RW         <= 1'b0;
            BE         <= 4'b0000;
            Addr       <= 30'h0000_0000;
            DataOut    <= 32'h0000_0000;
            RData      <= 32'h0000_0000;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            AddrErr    <= 1'b0;
            BusErr     <= 1'b0;
            toCount    <= 8'd0;
            latSize    <= 2'b00;
            latSignExt <= 1'b0;
        end else begin
            CS         <= csNext;
            RW         <= rwNext;
            BE         <= beNext;
            Addr       <= addrNext;
            DataOut    <= dataOutNext;
            RData      <= rDataNext;
            Busy       <= busyNext;
            Done       <= doneNext;
            AddrErr    <= addrErrNext;
            BusErr     <= busErrNext;
            toCount    <= toCountNext;
            latSize    <= latSizeNext;
            latSignExt <= latSignExtNext;
        end
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the simulated memory bus; the other end of the CS/BE/RW/Addr/DataReady protocol that the memory responder implements.
- Accepts one load/store request at a time from the MIPS-C datapath and converts it into a single memory bus cycle.
- Waits for the asynchronous DataReady handshake, then returns aligned, extended read data together with a one-cycle Done pulse.
- Flags misaligned accesses and bus timeouts so that the exception logic can act on them.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronising DataReady into Clk (minimum 2).
- TIMEOUT_CYCLES, 64, Clk cycles allowed in each wait state before the bus error fires (range 1..255).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  CPU request; sampled only in IDLE.
- Wr  in  1  1 = store, 0 = load.
- Size  in  2  00 = byte, 01 = half, 10 = word; 11 is reserved and treated as word.
- SignExt  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- VAddr  in  32  byte address.
- WData  in  32  store data, right-justified.
- Busy  out  1  high while a request is in progress.
- Done  out  1  one-cycle completion pulse.
- RData  out  32  load result; valid when Done is high and held until the next Done.
- AddrErr  out  1  misalignment flag; pulses together with Done.
- BusErr  out  1  timeout flag; pulses together with Done.
- CS  out  1  bus chip select; the memory acts on its rising edge.
- RW  out  1  bus direction: 1 = write, 0 = read.
- BE  out  4  byte-enable / size code.
- Addr  out  30  word address, bits [31:2].
- DataOut  out  32  write data to the memory DataIn.
- DataIn  in  32  read data from the memory DataOut.
- DataReady  in  1  memory ready; asynchronous to Clk.

Behaviour:
- Reset values: CS=0, RW=0, BE=0, Addr=0, DataOut=0, RData=0, Busy=0, Done=0, AddrErr=0, BusErr=0. FSM returns to IDLE; the synchroniser chain and the timeout counter are cleared.
- Reset during a transaction: CS drops to 0 immediately and asynchronously. No Done is produced and the request is lost.
- All outputs are registered. The bus uses right-justified data; the byte offset is not transmitted.
  - Byte: BE=0001, DataOut={24'b0, WData[7:0]}.
  - Half: BE=0011, DataOut={16'b0, WData[15:0]}.
  - Word: BE=1111, DataOut=WData.
  - Addr = VAddr[31:2].
- FSM states: IDLE, SETUP, STROBE, CAPTURE, RELEASE.
- IDLE:
  - If Req=1 and the access is misaligned (half with VAddr[0]=1, or word with VAddr[1:0]!=00): on the next edge assert Done=1 and AddrErr=1 for one cycle, stay in IDLE, issue no bus cycle, leave RData unchanged.
  - Else if Req=1: latch the request, drive Addr/BE/RW/DataOut with CS=0, set Busy=1, go to SETUP.
- SETUP (1 cycle): bus fields held stable; CS=1 on exit; go to STROBE.
- STROBE: hold CS=1 until the synchronised ready signal rdy_s=1, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Load: RData = DataIn[7:0] for byte or DataIn[15:0] for half, sign- or zero-extended per the latched SignExt; DataIn for word.
  - Store: RData unchanged.
  - CS=0 on exit; go to RELEASE.
- RELEASE: wait for rdy_s=0, then go to IDLE with Done=1 and Busy=0 on that same edge.
- Addr, BE, RW and DataOut stay constant from SETUP through RELEASE and change only when the next request is accepted.
- Timeout counter:
  - Cleared on entry to STROBE and to RELEASE; increments every cycle spent there.
  - On reaching TIMEOUT_CYCLES: CS=0, Done=1, BusErr=1, Busy=0, go to IDLE. RData is unchanged if the timeout occurs in STROBE.
- Back-to-back requests: Req held high during the Done cycle is accepted on the following edge. Minimum issue interval is therefore one idle cycle after Done.
- Req or field changes while Busy=1 are ignored.
- Busy is high exactly from the SETUP entry edge until the Done edge.
- Minimum latency from the Req-sampled edge to Done is 4 + 2×SYNC_STAGES cycles with zero memory delay.

Test Plan:
- Word store: VAddr=0x0000_0030, WData=0xDEAD_BEEF, Size=10 -> BE=1111, Addr=0x0C, RW=1, exactly one CS rising edge, Done pulse, memory word 12 = 0xDEAD_BEEF.
- Byte load with sign extension: memory word 5 = 0x0000_0080, VAddr=0x14, Size=00, SignExt=1 -> BE=0001, RData=0xFFFF_FF80; repeating with SignExt=0 -> RData=0x0000_0080.
- Misaligned half access at VAddr=0x0000_0013 -> Done and AddrErr high for one cycle, CS never rises, Busy stays 0.
- DataReady held at 0 with TIMEOUT_CYCLES=8 -> CS falls after 8 STROBE cycles, Done and BusErr pulse together, FSM back in IDLE; a following request completes normally.
- Reset asserted while in STROBE -> CS=0 asynchronously, all outputs at reset values, no Done; the next request after reset release completes normally.
- Two back-to-back word loads (Req held high) of words 9 and 10 -> two separate CS pulses, two Done pulses, RData equal to each word in order, Addr stable during each CS-high window.
